// File: rtl/rtc_field_editor.sv
// rtc_field_editor: front-panel edit engine for nine RTC fields with BCD write-back.
// Ports: CLK/reset, btn_*/mode/commit from the panel, rd_*/wr_* register port,
// cursor/edit_active/busy/done/err status. Optional macro: RTC_EDITOR_TIMEOUT_EN.
module rtc_field_editor #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter logic [AW-1:0] ADDR_TIME = 8'h21,
  parameter logic [AW-1:0] ADDR_DATE = 8'h24,
  parameter logic [AW-1:0] ADDR_ALARM = 8'h31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic [1:0]    mode,
  input  logic          commit,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic          rd_ack,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_ack,
  output logic [3:0]    cursor,
  output logic          edit_active,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef RTC_EDITOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_RD, S_CALC, S_WR, S_DONE
  } state_t;

  state_t      state;
  logic [6:0]  off [9];
  logic [3:0]  idx;
  logic [1:0]  mode_q;
  logic [7:0]  cap;
  logic [15:0] tmo;
  logic        err_q;
  logic        live;

  function automatic logic [6:0] fmin(input logic [3:0] i);
    return (i == 4'd3 || i == 4'd4) ? 7'd1 : 7'd0;
  endfunction

  function automatic logic [6:0] fmax(input logic [3:0] i);
    case (i)
      4'd2, 4'd8: return 7'd23;
      4'd3:       return 7'd31;
      4'd4:       return 7'd12;
      4'd5:       return 7'd99;
      default:    return 7'd59;
    endcase
  endfunction

  function automatic logic [AW-1:0] faddr(input logic [3:0] i);
    if (i < 4'd3)      return ADDR_TIME + AW'(i);
    else if (i < 4'd6) return ADDR_DATE + AW'(i - 4'd3);
    else               return ADDR_ALARM + AW'(i - 4'd6);
  endfunction

  // edit-side decode
  logic [3:0] base;
  logic [6:0] range_c;
  logic       can_edit;
  logic       up1, dn1, lf1, rt1;

  always_comb begin
    base = 4'd0;
    case (mode)
      2'd2:    base = 4'd3;
      2'd3:    base = 4'd6;
      default: base = 4'd0;
    endcase
    range_c = fmax(cursor) - fmin(cursor) + 7'd1;
    // presses are dropped in the cycle a mode change re-homes the cursor
    can_edit = live && (mode != 2'd0) && !busy && (mode == mode_q);
    up1 = btn_up & ~btn_down;
    dn1 = btn_down & ~btn_up;
    lf1 = btn_left & ~btn_right;
    rt1 = btn_right & ~btn_left;
  end

  // write-back arithmetic on the captured register value
  logic [3:0] hi, lo;
  logic [7:0] v8, mn8, mx8, rng8, v, n, r;
  logic       bcd_ok;
  logic [7:0] bcd;

  always_comb begin
    hi = cap[7:4];
    lo = cap[3:0];
    v8 = {4'd0, hi} * 8'd10 + {4'd0, lo};
    mn8 = {1'b0, fmin(idx)};
    mx8 = {1'b0, fmax(idx)};
    rng8 = mx8 - mn8 + 8'd1;
    bcd_ok = (hi < 4'd10) && (lo < 4'd10);
    v = (bcd_ok && v8 >= mn8 && v8 <= mx8) ? v8 : mn8;
    n = (v - mn8) + {1'b0, off[idx]};
    if (n >= rng8) n = n - rng8;
    r = n + mn8;
    bcd = {4'(r / 8'd10), 4'(r % 8'd10)};
  end

  assign edit_active = live & (mode != 2'd0) & ~busy;
  assign err = err_q & TMO_EN;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= 4'd0;
      cursor  <= 4'd0;
      mode_q  <= 2'd0;
      cap     <= 8'd0;
      tmo     <= 16'd0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_q   <= 1'b0;
      live    <= 1'b0;
      for (int i = 0; i < 9; i++) off[i] <= 7'd0;
    end else begin
      live   <= 1'b1;
      mode_q <= mode;
      done   <= 1'b0;
      err_q  <= 1'b0;

      if (mode != mode_q && mode != 2'd0) begin
        cursor <= base;
      end else if (can_edit) begin
        if (rt1)
          cursor <= (cursor == base + 4'd2) ? base : cursor + 4'd1;
        else if (lf1)
          cursor <= (cursor == base) ? base + 4'd2 : cursor - 4'd1;
        if (up1)
          off[cursor] <= (off[cursor] == range_c - 7'd1) ? 7'd0 : off[cursor] + 7'd1;
        else if (dn1)
          off[cursor] <= (off[cursor] == 7'd0) ? range_c - 7'd1 : off[cursor] - 7'd1;
      end

      case (state)
        S_IDLE: begin
          if (commit) begin
            busy  <= 1'b1;
            idx   <= 4'd0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (idx > 4'd8) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (off[idx] == 7'd0) begin
            if (idx == 4'd8) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= faddr(idx);
            tmo     <= 16'd0;
            state   <= S_RD;
          end
        end
        S_RD: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            cap    <= rd_data[7:0];
            state  <= S_CALC;
          end else if (TMO_EN && tmo == TMO_LAST) begin
            rd_req <= 1'b0;
            err_q  <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        S_CALC: begin
          wr_req  <= 1'b1;
          wr_addr <= faddr(idx);
          wr_data <= DW'(bcd);
          tmo     <= 16'd0;
          state   <= S_WR;
        end
        S_WR: begin
          if (wr_ack) begin
            wr_req   <= 1'b0;
            off[idx] <= 7'd0;
            idx      <= idx + 4'd1;
            state    <= S_SCAN;
          end else if (TMO_EN && tmo == TMO_LAST) begin
            wr_req <= 1'b0;
            err_q  <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_field_editor.sv
// tb_rtc_field_editor: scoreboard bench for rtc_field_editor.
// A register-port responder pops expected writes and compares them.
module tb_rtc_field_editor;
  logic       CLK = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [1:0] mode;
  logic       commit;
  logic       rd_req, rd_ack, wr_req, wr_ack;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [3:0] cursor;
  logic       edit_active, busy, done, err;

  always #5 CLK = ~CLK;

  rtc_field_editor #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .mode(mode), .commit(commit),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack),
    .cursor(cursor), .edit_active(edit_active),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem [256];
  logic       hold_rd = 1'b0;
  logic       hold_wr = 1'b0;
  int         rd_cnt = 0;
  int         rd0, lat, hi_cnt;
  bit         seen;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // register-port responder and write monitor
  always @(negedge CLK) begin
    wr_t e;
    if (reset) begin
      rd_ack = 1'b0;
      wr_ack = 1'b0;
    end else begin
      rd_ack = rd_req && !hold_rd;
      if (rd_req && !hold_rd) begin
        rd_data = mem[rd_addr];
        rd_cnt++;
      end
      wr_ack = wr_req && !hold_wr;
      if (wr_req && !hold_wr) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0h data %0h want none",
                   wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {8'd0, wr_addr}, {8'd0, e.a});
          chk("wr_data", {8'd0, wr_data}, {8'd0, e.d});
        end
        mem[wr_addr] = wr_data;
      end
    end
  end

  task automatic press(input int b);
    @(negedge CLK);
    case (b)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      3: btn_right = 1'b1;
      4: begin btn_up = 1'b1; btn_down = 1'b1; end
      default: begin btn_left = 1'b1; btn_right = 1'b1; end
    endcase
    @(negedge CLK);
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge CLK);
    mode = m;
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_commit();
    @(negedge CLK);
    commit = 1'b1;
    @(negedge CLK);
    commit = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, {15'd0, got}, 16'd1);
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h21] = 8'h58;
    mem[8'h25] = 8'h01;
    mem[8'h33] = 8'h23;
    mem[8'h24] = 8'h3A;
    reset = 1'b1;
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    mode = 2'd0;
    commit = 1'b0;
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    rd_data = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_rd_req", {15'd0, rd_req}, 16'd0);
    chk("rst_wr_req", {15'd0, wr_req}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_cursor", {12'd0, cursor}, 16'd0);
    chk("rst_edit", {15'd0, edit_active}, 16'd0);
    reset = 1'b0;

    // seconds 58 + 3 wraps to 01
    set_mode(2'd1);
    chk("t1_edit", {15'd0, edit_active}, 16'd1);
    chk("t1_cursor", {12'd0, cursor}, 16'd0);
    repeat (3) press(0);
    exp_q.push_back('{a: 8'h21, d: 8'h01});
    rd0 = rd_cnt;
    do_commit();
    wait_done("t1_done");
    chk("t1_reads", 16'(rd_cnt - rd0), 16'd1);

    // month 01 - 2 wraps to 11
    set_mode(2'd2);
    chk("t2_cursor", {12'd0, cursor}, 16'd3);
    press(3);
    chk("t2_right", {12'd0, cursor}, 16'd4);
    press(1);
    press(1);
    exp_q.push_back('{a: 8'h25, d: 8'h11});
    do_commit();
    wait_done("t2_done");

    // alarm hours 23 + 1 wraps to 00, left wraps 6 -> 8
    set_mode(2'd3);
    chk("t3_cursor", {12'd0, cursor}, 16'd6);
    press(2);
    chk("t3_left", {12'd0, cursor}, 16'd8);
    press(0);
    exp_q.push_back('{a: 8'h33, d: 8'h00});
    do_commit();
    wait_done("t3_done");

    // invalid BCD day treated as min
    set_mode(2'd2);
    chk("t4_cursor", {12'd0, cursor}, 16'd3);
    press(0);
    exp_q.push_back('{a: 8'h24, d: 8'h02});
    do_commit();
    wait_done("t4_done");

    // simultaneous presses cancel; zero-edit commit timing
    press(5);
    chk("t5_lr_both", {12'd0, cursor}, 16'd3);
    press(4);
    rd0 = rd_cnt;
    @(negedge CLK);
    commit = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      #1;
      if (n == 1) begin
        commit = 1'b0;
        chk("t5_busy", {15'd0, busy}, 16'd1);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("t5_latency", 16'(lat), 16'd10);
    @(posedge CLK);
    #1;
    chk("t5_busy_end", {15'd0, busy}, 16'd0);
    chk("t5_reads", 16'(rd_cnt - rd0), 16'd0);

    // reset during a held write
    set_mode(2'd1);
    press(0);
    hold_wr = 1'b1;
    do_commit();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK);
      #1;
      if (wr_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_wr_seen", {15'd0, seen}, 16'd1);
    reset = 1'b1;
    #1;
    chk("t6_wr_req", {15'd0, wr_req}, 16'd0);
    chk("t6_rd_req", {15'd0, rd_req}, 16'd0);
    chk("t6_busy", {15'd0, busy}, 16'd0);
    chk("t6_cursor", {12'd0, cursor}, 16'd0);
    chk("t6_edit", {15'd0, edit_active}, 16'd0);
    @(negedge CLK);
    reset = 1'b0;
    hold_wr = 1'b0;
    repeat (2) @(negedge CLK);
    rd0 = rd_cnt;
    do_commit();
    wait_done("t6_done");
    chk("t6_reads", 16'(rd_cnt - rd0), 16'd0);

    // read acknowledge withheld
    press(0);
    hold_rd = 1'b1;
    exp_q.push_back('{a: 8'h21, d: 8'h02});
    do_commit();
`ifdef RTC_EDITOR_TIMEOUT_EN
    seen = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (err) begin
        seen = 1'b1;
        break;
      end
      if (rd_req) hi_cnt++;
    end
    chk("t7_err", {15'd0, seen}, 16'd1);
    chk("t7_rd_cycles", 16'(hi_cnt), 16'd4);
    chk("t7_busy", {15'd0, busy}, 16'd0);
    chk("t7_rd_drop", {15'd0, rd_req}, 16'd0);
    @(negedge CLK);
    hold_rd = 1'b0;
    do_commit();
    wait_done("t7_retry_done");
`else
    repeat (20) @(posedge CLK);
    #1;
    chk("t7_rd_held", {15'd0, rd_req}, 16'd1);
    chk("t7_busy", {15'd0, busy}, 16'd1);
    chk("t7_err", {15'd0, err}, 16'd0);
    @(negedge CLK);
    hold_rd = 1'b0;
    wait_done("t7_done");
`endif
    repeat (3) @(negedge CLK);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
